// File: rtl/mux4_rr_arb_pkg.sv
// Shared types and encodings for the round-robin arbitrated 4:1 mux.
// Also holds the HOLD_MAX legality check and small index helpers.
package mux4_rr_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  localparam logic [1:0] SelA1 = 2'b00;
  localparam logic [1:0] SelA2 = 2'b01;
  localparam logic [1:0] SelA3 = 2'b10;
  localparam logic [1:0] SelA4 = 2'b11;

  function automatic bit hold_max_legal(int unsigned hold);
    return (hold >= 1) && (hold <= 15);
  endfunction

  // Requester index (1..4) to mux select code.
  function automatic logic [1:0] sel_of(logic [2:0] idx);
    return 2'(idx - 3'd1);
  endfunction

  // Requester index (1..4) to one-hot grant vector, bit 0 = requester 1.
  function automatic logic [3:0] onehot_of(logic [2:0] idx);
    return 4'b0001 << (idx - 3'd1);
  endfunction

endpackage

// File: rtl/mux4_rr_arb_pick.sv
// Combinational round-robin pick: searches req from ptr+1 upward, wrapping 4->1,
// with ptr itself ranked last.
module rr_pick4
  import mux4_rr_arb_pkg::*;
(
  input  logic [4:1] req,
  input  logic [2:0] ptr,
  output logic       valid,
  output logic [2:0] pick
);

  logic [3:0] req_z;
  logic [1:0] base;
  logic [1:0] cand;

  assign req_z = req;
  assign base  = 2'(ptr - 3'd1);

  // Walk from the lowest priority down so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    pick  = ptr;
    cand  = base;
    for (int k = 4; k >= 1; k--) begin
      cand = 2'(base + 2'(k));
      if (req_z[cand]) begin
        valid = 1'b1;
        pick  = {1'b0, cand} + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux. One owner holds the
// grant for at most HOLD_MAX cycles; the selected data bit is registered onto b.
module mux4_rr_arb
  import mux4_rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:1] req,
  input  logic [4:1] a,
  output logic [4:1] gnt,
  output logic [2:1] c,
  output logic       b,
  output logic       busy
);

  if (!hold_max_legal(HOLD_MAX)) begin : gen_hold_max_illegal
    $error("mux4_rr_arb: HOLD_MAX must be in 1..15");
  end

  localparam logic [3:0] HoldMax = 4'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:1] gnt_q, gnt_d;
  logic [1:0] c_q, c_d;
  logic       b_q, b_d;

  logic       pick_valid;
  logic [2:0] pick;
  logic       mux_bit;
  logic       own_req;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_comb begin
    mux_bit = a[1];
    case (c_q)
      SelA1: mux_bit = a[1];
      SelA2: mux_bit = a[2];
      SelA3: mux_bit = a[3];
      SelA4: mux_bit = a[4];
    endcase
  end

  assign own_req = req[ptr_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    c_d     = c_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          ptr_d   = pick;
          cnt_d   = 4'd1;
          gnt_d   = onehot_of(pick);
          c_d     = sel_of(pick);
        end
      end
      StGrant: begin
        b_d = mux_bit;
        if (own_req && (cnt_q < HoldMax)) begin
          cnt_d = cnt_q + 4'd1;
        end else if (pick_valid) begin
          // Handover (possibly back to the same owner) with no idle cycle.
          ptr_d = pick;
          cnt_d = 4'd1;
          gnt_d = onehot_of(pick);
          c_d   = sel_of(pick);
        end else begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'd4;
      cnt_q   <= '0;
      gnt_q   <= '0;
      c_q     <= SelA1;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      c_q     <= c_d;
      b_q     <= b_d;
    end
  end

  assign gnt  = gnt_q;
  assign c    = c_q;
  assign b    = b_q;
  assign busy = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Bench for mux4_rr_arb: four instances with different HOLD_MAX share stimulus and
// are checked every cycle against a behavioural round-robin model.
module tb_mux4_rr_arb;

  localparam int unsigned HM [4] = '{1, 2, 3, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:1] req = '0;
  logic [4:1] a   = '0;

  logic [4:1] gnt_w  [4];
  logic [2:1] c_w    [4];
  logic       b_w    [4];
  logic       busy_w [4];

  int n_vec  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    mux4_rr_arb #(.HOLD_MAX(HM[g])) u_dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .a    (a),
      .gnt  (gnt_w[g]),
      .c    (c_w[g]),
      .b    (b_w[g]),
      .busy (busy_w[g])
    );
  end

  // Behavioural model state per instance.
  int         m_ptr  [4];
  int         m_cnt  [4];
  bit         m_busy [4];
  logic [4:1] m_gnt  [4];
  logic [1:0] m_c    [4];
  logic       m_b    [4];

  function automatic int rr_pick(input logic [4:1] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = ((p - 1 + k) % 4) + 1;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int p;
      p = rr_pick(req, m_ptr[i]);
      if (rst) begin
        m_busy[i] = 1'b0; m_ptr[i] = 4; m_cnt[i] = 0;
        m_gnt[i]  = '0;   m_c[i]   = '0; m_b[i]  = 1'b0;
      end else if (!m_busy[i]) begin
        if (p != 0) begin
          m_busy[i] = 1'b1; m_ptr[i] = p; m_cnt[i] = 1;
          m_gnt[i] = 4'b0001 << (p - 1); m_c[i] = 2'(p - 1);
        end
      end else begin
        m_b[i] = a[m_ptr[i]];
        if (req[m_ptr[i]] && m_cnt[i] < int'(HM[i])) begin
          m_cnt[i] = m_cnt[i] + 1;
        end else if (p != 0) begin
          m_ptr[i] = p; m_cnt[i] = 1;
          m_gnt[i] = 4'b0001 << (p - 1); m_c[i] = 2'(p - 1);
        end else begin
          m_busy[i] = 1'b0; m_gnt[i] = '0;
        end
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (gnt_w[i] !== m_gnt[i] || c_w[i] !== m_c[i] || b_w[i] !== m_b[i]
            || busy_w[i] !== m_busy[i]) begin
          n_fail++;
          $display("FAIL model inst%0d t=%0t: got gnt=%b c=%b b=%b busy=%b want gnt=%b c=%b b=%b busy=%b",
                   i, $time, gnt_w[i], c_w[i], b_w[i], busy_w[i],
                   m_gnt[i], m_c[i], m_b[i], m_busy[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %b want %b", name, inst, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    for (int i = 0; i < 4; i++) begin
      chk({name, "_gnt"}, i, 8'(gnt_w[i]), 8'h00);
      chk({name, "_c"}, i, 8'(c_w[i]), 8'h00);
      chk({name, "_b"}, i, 8'(b_w[i]), 8'h00);
      chk({name, "_busy"}, i, 8'(busy_w[i]), 8'h00);
    end
  endtask

  initial begin
    // Reset held two cycles with everyone requesting.
    rst = 1'b1; req = 4'b1111; a = '0;
    step(); chk_reset_outs("rst1");
    step(); chk_reset_outs("rst2");
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk("first_after_rst", i, 8'(gnt_w[i]), 8'b0001);

    // Hold expiry on HOLD_MAX=3: owners 1,2,3,4,1 each for 3 cycles.
    for (int t = 1; t <= 12; t++) begin
      logic [3:0] want;
      want = 4'b0001 << ((t / 3) % 4);
      step();
      chk("hold3_gnt", 2, 8'(gnt_w[2]), 8'(want));
      chk("hold3_busy", 2, 8'(busy_w[2]), 8'h01);
    end

    // First pick after reset, then handover on release.
    rst = 1'b1; req = 4'b1010;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("pick2_gnt", i, 8'(gnt_w[i]), 8'b0010);
      chk("pick2_c", i, 8'(c_w[i]), 8'b01);
    end
    req = 4'b1000;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("handover_gnt", i, 8'(gnt_w[i]), 8'b1000);
      chk("handover_c", i, 8'(c_w[i]), 8'b11);
    end

    // Sole requester keeps the grant across expiry with no gap.
    rst = 1'b1; req = 4'b0100;
    step();
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        chk("sole_gnt", i, 8'(gnt_w[i]), 8'b0100);
        chk("sole_busy", i, 8'(busy_w[i]), 8'h01);
        chk("sole_c", i, 8'(c_w[i]), 8'b10);
      end
    end

    // Datapath: owner 3, a[3] toggles 1,0,1 with the other bits inverted.
    a = 4'b0100; step(); chk("data1", 3, 8'(b_w[3]), 8'h01);
    a = 4'b1011; step(); chk("data0", 3, 8'(b_w[3]), 8'h00);
    a = 4'b0100; step(); chk("data1b", 3, 8'(b_w[3]), 8'h01);

    // Reset in the middle of a grant, then ptr must be back at 4.
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0010;
    step(); step();
    rst = 1'b1; req = 4'b0110;
    step(); chk_reset_outs("rst_mid");
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) chk("post_rst_gnt", i, 8'(gnt_w[i]), 8'b0010);

    // Randomised phase against the model.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      a   = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arb.md
# mux4_rr_arb

Round-robin arbiter that shares one 4:1 single-bit mux datapath between four requesters. It accepts per-requester requests, grants one owner at a time with a bounded hold time, and drives the mux select from the grant. It also registers the selected data bit as the block output. It sits in front of the 4:1 mux datapath and replaces any static select wiring with a sequenced, fair schedule.

## Interface
- HOLD_MAX, 8, maximum consecutive cycles one owner keeps the grant; legal range 1..15
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  [4:1]  request per requester; bit i = requester i
- a  input  [4:1]  data bit per requester; bit i = requester i
- gnt  output  [4:1]  registered one-hot grant, or all-zero when idle
- c  output  [2:1]  registered mux select; 2'b00→a[1], 2'b01→a[2], 2'b10→a[3], 2'b11→a[4]
- b  output  1  registered mux output, b <= a[owner]
- busy  output  1  registered; 1 while state is GRANT

## Operation
- States: IDLE, GRANT. Internal registers: owner pointer ptr (1..4), hold counter cnt (4 bits).
- Reset values: gnt=4'b0000, c=2'b00, b=0, busy=0, state=IDLE, ptr=4, cnt=0.
- The round-robin pick searches req in the order ptr+1, ptr+2, ptr+3, ptr, wrapping 4→1. The first set bit wins.
- IDLE, req==0: stay in IDLE. gnt=0, c holds, b holds.
- IDLE, req!=0: at the edge, gnt=onehot(pick), c=pick-1, ptr=pick, cnt=1, state=GRANT.
- GRANT, each edge: b <= a[ptr].
- The owner keeps the grant while req[ptr]=1 and cnt<HOLD_MAX. On each such edge, cnt increments.
- Release event: req[ptr]=0, or cnt==HOLD_MAX.
  - If a pick exists, that pick becomes the new owner at the same edge: gnt, c and ptr update and cnt=1. There is no idle cycle.
  - The pick may be the old owner, which happens at hold expiry when only the owner is requesting. In that case gnt stays asserted and cnt=1.
  - If no pick exists, state=IDLE, gnt=0, busy=0, and c holds its last value.
- Fairness: at hold expiry the current owner ranks last. A continuously requesting requester waits at most 3·HOLD_MAX cycles.
- gnt is always one-hot or zero. c always equals the encoded index of ptr.

## Timing
- Request to grant: req sampled high at edge k gives gnt high after edge k, provided the arbiter is IDLE or a release occurs at k.
- Data: the owner drives a[i] in the cycle after gnt rises. b reflects a[owner] as sampled at the next edge, so b has 1 cycle of latency from select.
- Release: the owner drops req before edge k, and gnt changes at edge k. The old owner therefore receives at most 1 extra granted cycle after its last requesting cycle.
- Hold: a single owner is granted for exactly HOLD_MAX consecutive cycles before rotation, when others are waiting. With HOLD_MAX=1, the grant rotates every cycle among the requesters.
- Reset mid-GRANT: at the edge where rst=1, all registers return to their reset values. gnt drops in that same edge, and no data is captured that cycle. rst overrides any release or pick.
- A simultaneous release and new request from a non-owner is a handover at the same edge, per the release rules.

## Structure
- Shared package/header: state encodings (IDLE=1'b0, GRANT=1'b1), select encodings (SEL_A1..SEL_A4 = 2'b00..2'b11), and a HOLD_MAX legality check.
- One natural sub-module: rr_pick4. It is combinational and takes req[4:1] and ptr. It outputs a valid flag and the picked index (1..4). It is instantiated once.
- The mux in the top level is a plain case on c. It is not re-instantiated as a separate block.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=4'b1111. Require gnt=0, c=00, b=0 and busy=0 throughout, and gnt=4'b0001 one cycle after rst falls.
- First pick after reset: req=4'b1010. Require gnt=4'b0010 and c=01 after one edge, with ptr at 2. On the owner's release, gnt=4'b1000 and c=11 at the same edge.
- Hold expiry: HOLD_MAX=3 with req=4'b1111 constant. Require a grant sequence of 1,2,3,4,1, each owner held for exactly 3 cycles, with no zero-gnt cycles.
- Sole owner at expiry: HOLD_MAX=2 with req=4'b0100. Require gnt=4'b0100 continuously, busy=1, and no gap.
- Datapath: owner 3 granted, a toggling 1,0,1 on bit 3 with the other bits at the inverse value. Require b=1,0,1 delayed by 1 cycle.
- Reset mid-grant: owner 2 with cnt=2, then assert rst for 1 cycle. Require all outputs at reset values on the next cycle. Afterwards, with req=4'b0110, require the first grant to be 4'b0010 (ptr back at 4).
